// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type and default width for the restoring divider
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    state_idle = 2'd0,
    state_run  = 2'd1,
    state_done = 2'd2
  } state_t;

endpackage

// File: rtl/div32x32_fsm.sv
// rtl/div32x32_fsm.sv - divider control: state, step counter, busy/done, load/shift enables
module div32x32_fsm
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic divisor_zero,
  output logic busy,
  output logic done,
  output logic load,
  output logic load_zero,
  output logic shift
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  // State and step counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= state_idle;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and datapath enables; start is only honoured outside state_run
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    load_zero = 1'b0;
    shift     = 1'b0;
    case (state)
      state_idle, state_done: begin
        done = (state == state_done);
        if (start) begin
          cnt_nxt = '0;
          if (divisor_zero) begin
            load_zero = 1'b1;
            state_nxt = state_done;
          end else begin
            load      = 1'b1;
            state_nxt = state_run;
          end
        end else begin
          state_nxt = state_idle;
        end
      end
      state_run: begin
        busy    = 1'b1;
        shift   = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = state_done;
        end
      end
      default: begin
        state_nxt = state_idle;
      end
    endcase
  end

endmodule

// File: rtl/div32x32.sv
// rtl/div32x32.sv - unsigned restoring divider, one quotient bit per cycle
module div32x32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic             load, load_zero, shift, divisor_zero;
  logic [WIDTH-1:0] dvsr_q, quo_q, rem_q, rem_nxt;
  logic [WIDTH:0]   partial;
  logic             take;
  logic             dbz_q;

  assign divisor_zero = (divisor == '0);

  div32x32_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .divisor_zero (divisor_zero),
    .busy         (busy),
    .done         (done),
    .load         (load),
    .load_zero    (load_zero),
    .shift        (shift)
  );

  // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  // The low-WIDTH subtraction is exact whenever it is taken, since the result is below the divisor.
  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    take    = (partial >= {1'b0, dvsr_q});
    rem_nxt = take ? (partial[WIDTH-1:0] - dvsr_q) : partial[WIDTH-1:0];
  end

  // Operand/result registers; the quotient register starts out holding the dividend and shifts it out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (load) begin
      dvsr_q <= divisor;
      quo_q  <= dividend;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else if (load_zero) begin
      dvsr_q <= divisor;
      quo_q  <= '1;
      rem_q  <= dividend;
      dbz_q  <= 1'b1;
    end else if (shift) begin
      rem_q  <= rem_nxt;
      quo_q  <= {quo_q[WIDTH-2:0], take};
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32x32.sv
// tb/tb_div32x32.sv - scoreboard bench for div32x32 against an arithmetic reference
module tb_div32x32;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_edge;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  logic [W-1:0] held_q = '0, held_r = '0;
  logic         held_dbz = 1'b0;

  div32x32 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // drive start in the current cycle and predict the response
  task automatic drive_now(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.done_edge = edge_n + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.done_edge = edge_n + 1 + W;
    end
    sb.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive_now(a, b);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, (b == 0) ? 32'd0 : 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_done actual=timeout required=done");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
  endtask

  // monitor: every done pulse is matched against the oldest prediction
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
        chk("done_latency", edge_n, e.done_edge);
        chk("busy_in_done", {31'b0, busy}, 32'd0);
        held_q = e.q; held_r = e.r; held_dbz = e.dbz;
      end
    end
  end

  task automatic chk_hold();
    repeat (3) @(negedge clk);
    chk("hold_quotient", quotient, held_q);
    chk("hold_remainder", remainder, held_r);
    chk("hold_dbz", {31'b0, div_by_zero}, {31'b0, held_dbz});
  endtask

  initial begin
    logic [W-1:0] a, b;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    reset = 1'b0;

    issue(32'd100, 32'd7);           drain(); chk_hold();
    issue(32'hFFFFFFFF, 32'd1);      drain();
    issue(32'd3, 32'd10);            drain();
    issue(32'h80000000, 32'hFFFFFFFF); drain();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF); drain();
    issue(32'd5, 32'd0);             drain(); chk_hold();

    // start while busy is ignored
    issue(32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start in the done cycle is taken back-to-back
    issue(32'd100, 32'd7);
    wait_done();
    drive_now(32'd9, 32'd3);
    @(negedge clk);
    start = 1'b0;
    chk("busy_back_to_back", {31'b0, busy}, 32'd1);
    drain();

    // reset mid-division
    issue(32'd100, 32'd7);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_quotient", quotient, 32'd0);
    chk("mid_rst_remainder", remainder, 32'd0);
    chk("mid_rst_dbz", {31'b0, div_by_zero}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(32'd20, 32'd6); drain();

    // randomized operands
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        default: begin b = $urandom; a = $urandom_range(0, 1000); end
      endcase
      issue(a, b);
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div32x32.md
DIV32X32 -- requirements
Module: div32x32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand/result width; all widths below are WIDTH unless stated otherwise.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request a division; sampled only when not busy.
REQ-005 The block SHALL have port dividend  input  WIDTH  unsigned dividend, sampled with an accepted start.
REQ-006 The block SHALL have port divisor  input  WIDTH  unsigned divisor, sampled with an accepted start.
REQ-007 The block SHALL have port busy  output  1  division in progress; start is ignored while high.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse: results valid.
REQ-009 The block SHALL have port quotient  output  WIDTH  registered unsigned quotient.
REQ-010 The block SHALL have port remainder  output  WIDTH  registered unsigned remainder.
REQ-011 The block SHALL have port div_by_zero  output  1  registered flag: last accepted divisor was zero.

Function
REQ-012 The state machine SHALL have states state_idle, state_run, state_done.
REQ-013 start SHALL be accepted in state_idle and state_done; on acceptance it SHALL latch dividend and divisor, clear remainder and div_by_zero, and move to state_run with step counter 0.
REQ-014 If the latched divisor is zero, acceptance SHALL instead go directly to state_done with quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-015 Each state_run cycle SHALL do one restoring step: p = {rem, q MSB} (WIDTH+1 bits); if p >= divisor then rem = p - divisor and shift 1 into q LSB, else rem = p[WIDTH-1:0] and shift 0 into q LSB.
REQ-016 After exactly WIDTH state_run cycles the FSM SHALL move to state_done; counter width SHALL be clog2(WIDTH)+1 bits.
REQ-017 Latency: start accepted at edge k SHALL give done = 1 during cycle k+WIDTH+1 (k+1 for divide-by-zero).
REQ-018 busy SHALL be 1 exactly in state_run; done SHALL be 1 exactly in state_done.
REQ-019 state_done SHALL last one cycle, then return to state_idle unless start is accepted in that cycle.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from state_done until the next accepted start.
REQ-021 start asserted while busy SHALL be ignored, with no effect on operands or results.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.

Reset
REQ-023 Asserting reset at any time, including mid-division, SHALL force state_idle with busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0.
REQ-024 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-025 A shared package div_pkg SHALL hold the state enum type (state_idle, state_run, state_done) and the default WIDTH constant.
REQ-026 Control SHALL be split into one sub-module, div32x32_fsm (state, counter, busy/done, load/shift enables); the top SHALL hold the operand, quotient and remainder registers and the subtract/compare datapath.

Verification
REQ-027 100 / 7 -> done at cycle 33, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-028 0xFFFFFFFF / 1 -> quotient = 0xFFFFFFFF, remainder = 0; 3 / 10 -> quotient = 0, remainder = 3.
REQ-029 0x80000000 / 0xFFFFFFFF -> quotient = 0, remainder = 0x80000000; 0xFFFFFFFF / 0xFFFFFFFF -> quotient = 1, remainder = 0.
REQ-030 5 / 0 -> done at cycle 1, quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1, busy never high.
REQ-031 Start 100 / 7, then pulse start with 9 / 3 at cycle 5 -> second start ignored, result 14 r 2; start 9 / 3 in the done cycle -> accepted back-to-back, result 3 r 0.
REQ-032 Assert reset at cycle 10 of 100 / 7 -> all outputs 0 and state_idle immediately; a following 20 / 6 -> quotient 3, remainder 2.
